// File: rtl/dmem_access_stage.sv
// Y86-64 memory-access (M) stage: M pipeline register plus byte-addressed data memory
// with 8-byte little-endian loads/stores and MEM_LAT wait cycles. Optional macro DMEM_ALIGN_CHECK_EN.
module dmem_access_stage #(
    parameter int DMEM_BYTES = 1024,
    parameter int MEM_LAT    = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        bubble_i,
    input  logic [3:0]  icode_i,
    input  logic [2:0]  stat_i,
    input  logic [63:0] valA_i,
    input  logic [63:0] valE_i,
    input  logic [3:0]  dstE_i,
    input  logic [3:0]  dstM_i,
    output logic [3:0]  icode_o,
    output logic [2:0]  stat_o,
    output logic [63:0] valM_o,
    output logic [63:0] valE_o,
    output logic [63:0] valA_o,
    output logic [3:0]  dstE_o,
    output logic [3:0]  dstM_o,
    output logic        busy_o
);
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'h1;
    localparam logic [2:0] SADR    = 3'h3;

    localparam int          AW       = $clog2(DMEM_BYTES);
    localparam logic [63:0] ADDR_MAX = 64'(DMEM_BYTES - 8);
    localparam logic [3:0]  LAT      = 4'(MEM_LAT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    logic [3:0]  icode_q, icode_d, dstE_q, dstE_d, dstM_q, dstM_d, wcnt_q, wcnt_d;
    logic [2:0]  stat_q, stat_d;
    logic [63:0] valA_q, valA_d, valE_q, valE_d;
    logic        committed_q, committed_d;
    state_t      state_q, state_d;

    logic [7:0]  mem_q [DMEM_BYTES];

    logic [63:0] addr, in_addr, rd_word;
    logic [AW-1:0] idx;
    logic        dmem_err, busy, capture, do_store, in_go;

    function automatic logic is_wr(input logic [3:0] ic);
        return (ic == IRMMOVQ) || (ic == IPUSHQ) || (ic == ICALL);
    endfunction

    function automatic logic is_rd(input logic [3:0] ic);
        return (ic == IMRMOVQ) || (ic == IPOPQ) || (ic == IRET);
    endfunction

    function automatic logic [63:0] acc_addr(input logic [3:0] ic, input logic [63:0] va,
                                             input logic [63:0] ve);
        return ((ic == IPOPQ) || (ic == IRET)) ? va : ve;
    endfunction

    function automatic logic acc_err(input logic [3:0] ic, input logic [63:0] a);
        logic bad;
        bad = a > ADDR_MAX;
`ifdef DMEM_ALIGN_CHECK_EN
        bad = bad | (a[2:0] != 3'd0);
`endif
        return (is_wr(ic) | is_rd(ic)) & bad;
    endfunction

    assign addr     = acc_addr(icode_q, valA_q, valE_q);
    assign dmem_err = acc_err(icode_q, addr);
    assign idx      = addr[AW-1:0];
    assign busy     = wcnt_q != 4'd0;
    assign capture  = ~bubble_i & ~stall_i & ~busy;
    assign in_addr  = acc_addr(icode_i, valA_i, valE_i);
    assign in_go    = (is_wr(icode_i) | is_rd(icode_i)) & ~acc_err(icode_i, in_addr);
    // committed_q keeps a held store from rewriting while downstream stalls
    assign do_store = (state_q == S_DONE) & is_wr(icode_q) & ~dmem_err & ~committed_q;

    always_comb begin
        icode_d     = icode_q;
        stat_d      = stat_q;
        valA_d      = valA_q;
        valE_d      = valE_q;
        dstE_d      = dstE_q;
        dstM_d      = dstM_q;
        wcnt_d      = busy ? wcnt_q - 4'd1 : wcnt_q;
        committed_d = committed_q | do_store;
        state_d     = state_q;
        if (state_q == S_WAIT && wcnt_q == 4'd1) state_d = S_DONE;
        if (bubble_i) begin
            icode_d     = INOP;
            stat_d      = SAOK;
            valA_d      = '0;
            valE_d      = '0;
            dstE_d      = RNONE;
            dstM_d      = RNONE;
            wcnt_d      = '0;
            committed_d = 1'b0;
            state_d     = S_IDLE;
        end else if (capture) begin
            icode_d     = icode_i;
            stat_d      = stat_i;
            valA_d      = valA_i;
            valE_d      = valE_i;
            dstE_d      = dstE_i;
            dstM_d      = dstM_i;
            wcnt_d      = in_go ? LAT : 4'd0;
            committed_d = 1'b0;
            if (!in_go)         state_d = S_IDLE;
            else if (LAT != 0)  state_d = S_WAIT;
            else                state_d = S_DONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            icode_q     <= INOP;
            stat_q      <= SAOK;
            valA_q      <= '0;
            valE_q      <= '0;
            dstE_q      <= RNONE;
            dstM_q      <= RNONE;
            wcnt_q      <= '0;
            committed_q <= 1'b0;
            state_q     <= S_IDLE;
        end else begin
            icode_q     <= icode_d;
            stat_q      <= stat_d;
            valA_q      <= valA_d;
            valE_q      <= valE_d;
            dstE_q      <= dstE_d;
            dstM_q      <= dstM_d;
            wcnt_q      <= wcnt_d;
            committed_q <= committed_d;
            state_q     <= state_d;
        end
    end

    // Memory has no reset; contents survive rst_i
    always_ff @(posedge clk_i) begin
        if (do_store)
            for (int b = 0; b < 8; b++) mem_q[idx + AW'(b)] <= valA_q[8*b +: 8];
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < 8; b++) rd_word[8*b +: 8] = mem_q[idx + AW'(b)];
    end

    assign valM_o  = ((state_q == S_DONE) && is_rd(icode_q) && !dmem_err && !busy) ? rd_word : '0;
    assign stat_o  = (stat_q != SAOK) ? stat_q : (dmem_err ? SADR : SAOK);
    assign icode_o = icode_q;
    assign valE_o  = valE_q;
    assign valA_o  = valA_q;
    assign dstE_o  = dstE_q;
    assign dstM_o  = dstM_q;
    assign busy_o  = busy;
endmodule

// File: tb/tb_dmem_access_stage.sv
// Bench for dmem_access_stage: two instances (MEM_LAT=0 and 2) driven by directed and random
// Y86 memory ops, checked against a byte-array reference model.
module tb_dmem_access_stage;
    localparam int NB = 1024;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst [2];
    logic        stall [2];
    logic        bubble [2];
    logic [3:0]  icode [2];
    logic [2:0]  stat [2];
    logic [63:0] valA [2];
    logic [63:0] valE [2];
    logic [3:0]  dstE [2];
    logic [3:0]  dstM [2];
    logic [3:0]  icode_o [2];
    logic [2:0]  stat_o [2];
    logic [63:0] valM_o [2];
    logic [63:0] valE_o [2];
    logic [63:0] valA_o [2];
    logic [3:0]  dstE_o [2];
    logic [3:0]  dstM_o [2];
    logic        busy_o [2];

    logic [7:0]  mm [2][NB];
    int          passed = 0, total = 0, fails = 0;

    always #5 clk = ~clk;

    dmem_access_stage #(.DMEM_BYTES(NB), .MEM_LAT(0)) u0 (
        .clk_i(clk), .rst_i(rst[0]), .stall_i(stall[0]), .bubble_i(bubble[0]),
        .icode_i(icode[0]), .stat_i(stat[0]), .valA_i(valA[0]), .valE_i(valE[0]),
        .dstE_i(dstE[0]), .dstM_i(dstM[0]), .icode_o(icode_o[0]), .stat_o(stat_o[0]),
        .valM_o(valM_o[0]), .valE_o(valE_o[0]), .valA_o(valA_o[0]), .dstE_o(dstE_o[0]),
        .dstM_o(dstM_o[0]), .busy_o(busy_o[0]));

    dmem_access_stage #(.DMEM_BYTES(NB), .MEM_LAT(2)) u1 (
        .clk_i(clk), .rst_i(rst[1]), .stall_i(stall[1]), .bubble_i(bubble[1]),
        .icode_i(icode[1]), .stat_i(stat[1]), .valA_i(valA[1]), .valE_i(valE[1]),
        .dstE_i(dstE[1]), .dstM_i(dstM[1]), .icode_o(icode_o[1]), .stat_o(stat_o[1]),
        .valM_o(valM_o[1]), .valE_o(valE_o[1]), .valA_o(valA_o[1]), .dstE_o(dstE_o[1]),
        .dstM_o(dstM_o[1]), .busy_o(busy_o[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk({tag, "_icode"}, icode_o[k], 4'h1);
        chk({tag, "_stat"},  stat_o[k], 3'h1);
        chk({tag, "_valE"},  valE_o[k], 0);
        chk({tag, "_valA"},  valA_o[k], 0);
        chk({tag, "_valM"},  valM_o[k], 0);
        chk({tag, "_dstE"},  dstE_o[k], 4'hF);
        chk({tag, "_dstM"},  dstM_o[k], 4'hF);
        chk({tag, "_busy"},  busy_o[k], 0);
    endtask

    // One instruction through DUT k; expected timing/values come from the architectural rules.
    task automatic exec(input int k, input logic [3:0] ic, input logic [2:0] st,
                        input logic [63:0] va, input logic [63:0] ve,
                        input logic [3:0] de, input logic [3:0] dm);
        logic rd, wr, err;
        logic [63:0] a, exp_m;
        logic [2:0] exp_s;
        int lat;
        @(negedge clk);
        icode[k] = ic; stat[k] = st; valA[k] = va; valE[k] = ve;
        dstE[k] = de; dstM[k] = dm; stall[k] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        stall[k] = 1'b1;
        wr  = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        rd  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        a   = (ic == 4'h9 || ic == 4'hB) ? va : ve;
        err = (rd || wr) && ((a > 64'(NB - 8)) || (ALIGN && a[2:0] != 3'd0));
        lat = ((rd || wr) && !err) ? (k == 1 ? 2 : 0) : 0;
        for (int c = 0; c < lat; c++) begin
            chk($sformatf("busy_wait%0d_k%0d", c, k), busy_o[k], 1);
            chk($sformatf("valM_wait%0d_k%0d", c, k), valM_o[k], 0);
            // stall and inputs must be ignored while busy
            icode[k] = 4'h1; valE[k] = {$urandom, $urandom};
            stall[k] = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
        end
        stall[k] = 1'b1;
        exp_m = '0;
        if (rd && !err)
            for (int b = 0; b < 8; b++) exp_m[8*b +: 8] = mm[k][int'(a) + b];
        exp_s = (st != 3'h1) ? st : (err ? 3'h3 : 3'h1);
        chk($sformatf("busy_done_k%0d", k), busy_o[k], 0);
        chk($sformatf("icode_k%0d", k), icode_o[k], ic);
        chk($sformatf("stat_k%0d_a%0h", k, a), stat_o[k], exp_s);
        chk($sformatf("valM_k%0d_a%0h", k, a), valM_o[k], exp_m);
        chk($sformatf("valE_k%0d", k), valE_o[k], ve);
        chk($sformatf("valA_k%0d", k), valA_o[k], va);
        chk($sformatf("dstE_k%0d", k), dstE_o[k], de);
        chk($sformatf("dstM_k%0d", k), dstM_o[k], dm);
        if (wr && !err)
            for (int b = 0; b < 8; b++) mm[k][int'(a) + b] = va[8*b +: 8];
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] raddr();
        case ($urandom_range(0, 7))
            0:       return 64'hFFFF_FFFF_FFFF_FFF8;
            1:       return 64'(NB - int'($urandom_range(1, 8)));
            2:       return 64'($urandom_range(0, NB - 1));
            default: return 64'($urandom_range(0, NB / 8 - 1) * 8);
        endcase
    endfunction

    function automatic logic [3:0] rop();
        case ($urandom_range(0, 9))
            0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'h4;
            4: return 4'h5;  5: return 4'h6;  6: return 4'h8;  7: return 4'h9;
            8: return 4'hA;  default: return 4'hB;
        endcase
    endfunction

    initial begin
        logic [63:0] d;
        logic [3:0] op;
        logic [2:0] st;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; stall[k] = 1'b1; bubble[k] = 1'b0;
            icode[k] = 4'h1; stat[k] = 3'h1; valA[k] = '0; valE[k] = '0;
            dstE[k] = 4'hF; dstM[k] = 4'hF;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) rst[k] = 1'b0;
        chk_reset(0, "rst0");
        chk_reset(1, "rst1");

        // Fill both memories with known words
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < NB / 8; w++)
                exec(k, 4'h4, 3'h1, {$urandom, $urandom}, 64'(w * 8), 4'hF, 4'hF);

        // Store/load round trip at zero latency
        exec(0, 4'h4, 3'h1, 64'h1122334455667788, 64'h100, 4'hF, 4'hF);
        chk("rt_byte100", u0.mem_q[256], 8'h88);
        exec(0, 4'h5, 3'h1, 64'h0, 64'h100, 4'hF, 4'h3);
        @(negedge clk);
        chk("rt_valM_hold", valM_o[0], 64'h1122334455667788);

        // Range boundary on both latencies
        for (int k = 0; k < 2; k++) begin
            exec(k, 4'h5, 3'h1, 64'h0, 64'h3F9, 4'hF, 4'h1);
            exec(k, 4'h5, 3'h1, 64'h0, 64'h3F8, 4'hF, 4'h1);
            exec(k, 4'h4, 3'h1, 64'hDEAD, 64'h400, 4'hF, 4'hF);
        end

        // Latency: popq from 0x200
        exec(1, 4'hB, 3'h1, 64'h200, 64'h208, 4'h4, 4'h0);

        // Bubble in the second wait cycle aborts a pushq
        @(negedge clk);
        icode[1] = 4'hA; stat[1] = 3'h1; valA[1] = 64'hA5A5_5A5A_0F0F_F0F0; valE[1] = 64'h40;
        dstE[1] = 4'h4; dstM[1] = 4'hF; stall[1] = 1'b0;
        @(posedge clk); @(negedge clk);
        stall[1] = 1'b1;
        chk("bub_busy_c1", busy_o[1], 1);
        @(posedge clk); @(negedge clk);
        chk("bub_busy_c2", busy_o[1], 1);
        bubble[1] = 1'b1;
        @(posedge clk); @(negedge clk);
        bubble[1] = 1'b0;
        chk("bub_busy_after", busy_o[1], 0);
        chk("bub_icode", icode_o[1], 4'h1);
        chk("bub_dstE", dstE_o[1], 4'hF);
        repeat (3) @(posedge clk);
        exec(1, 4'h5, 3'h1, 64'h0, 64'h40, 4'hF, 4'h2);

        // Asynchronous reset during WAIT drops the store
        @(negedge clk);
        icode[1] = 4'hA; stat[1] = 3'h1; valA[1] = 64'h0123_4567_89AB_CDEF; valE[1] = 64'h48;
        dstE[1] = 4'h4; dstM[1] = 4'hF; stall[1] = 1'b0;
        @(posedge clk); @(negedge clk);
        stall[1] = 1'b1;
        chk("rstw_busy_pre", busy_o[1], 1);
        #2 rst[1] = 1'b1;
        #1 chk_reset(1, "rstw");
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (4) @(posedge clk);
        exec(1, 4'h5, 3'h1, 64'h0, 64'h48, 4'hF, 4'h2);

        // Misaligned store then load
        exec(0, 4'h4, 3'h1, 64'hCAFE_F00D_1234_5678, 64'h104, 4'hF, 4'hF);
        exec(0, 4'h5, 3'h1, 64'h0, 64'h104, 4'hF, 4'h1);
        exec(0, 4'h5, 3'h1, 64'h0, 64'h100, 4'hF, 4'h1);

        // Random mix on both instances
        for (int n = 0; n < 150; n++)
            for (int k = 0; k < 2; k++) begin
                op = rop();
                d  = {$urandom, $urandom};
                st = 3'h1;
                if (!(op == 4'h4 || op == 4'h8 || op == 4'hA) && $urandom_range(0, 4) == 0)
                    st = $urandom_range(0, 1) ? 3'h2 : 3'h4;
                if (op == 4'h9 || op == 4'hB) exec(k, op, st, raddr(), d, 4'($urandom), 4'($urandom));
                else                           exec(k, op, st, d, raddr(), 4'($urandom), 4'($urandom));
            end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
